// File: rtl/instruction_prefetch_queue_pkg.sv
// Shared defaults and decode field indices for the instruction prefetch queue.
// Optional zero-cycle fetch-to-IR bypass is enabled by defining IPQ_BYPASS_EN.
package instruction_prefetch_queue_pkg;

  localparam int WIDTH_DEF   = 16;
  localparam int FIELD_W_DEF = 4;
  localparam int DEPTH_DEF   = 4;
  localparam int NFIELD_DEF  = WIDTH_DEF / FIELD_W_DEF;

  // Field k of the IR is irFields[k*FIELD_W +: FIELD_W]; the opcode is the top field.
  localparam int FLD_OPCODE = NFIELD_DEF - 1;
  localparam int FLD_2      = 2;
  localparam int FLD_1      = 1;
  localparam int FLD_0      = 0;

endpackage

// File: rtl/instruction_prefetch_queue_if.sv
// Fetch/decode bus of the instruction prefetch queue: memory push side,
// IR pop/flush control and the decoded IR fields.
interface instruction_prefetch_queue_if
  import instruction_prefetch_queue_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) ();
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] memData;
  logic             memValid;
  logic             memReady;
  logic             IRWrite;
  logic             flush;
  logic [WIDTH-1:0] irFields;
  logic             irValid;
  logic [CW-1:0]    count;

  modport master (
    output memData, memValid, IRWrite, flush,
    input  memReady, irFields, irValid, count
  );

  modport slave (
    input  memData, memValid, IRWrite, flush,
    output memReady, irFields, irValid, count
  );
endinterface

// File: rtl/instruction_prefetch_queue_fifo.sv
// ipq_fifo: circular word store for the prefetch queue. count is exact;
// full/empty are derived from it. clear has priority over push and pop.
module ipq_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/instruction_prefetch_queue.sv
// Instruction prefetch queue: FIFO of fetched words feeding the instruction
// register. Optional zero-cycle bypass of an empty queue under IPQ_BYPASS_EN.
module instruction_prefetch_queue
  import instruction_prefetch_queue_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int FIELD_W = FIELD_W_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  instruction_prefetch_queue_if.slave bus
);
  localparam int NFIELD = WIDTH / FIELD_W;

  logic [WIDTH-1:0] head;
  logic             full;
  logic             empty;
  logic             bypass;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] ir_p1;
  logic             vld_p1;

`ifdef IPQ_BYPASS_EN
  assign bypass = empty && bus.memValid && bus.IRWrite && !bus.flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word goes straight to the IR and is never queued.
  assign push = bus.memValid && !bus.flush && !bypass;
  assign pop  = bus.IRWrite && !empty && !bus.flush;

  ipq_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (bus.flush),
    .push  (push),
    .pop   (pop),
    .wdata (bus.memData),
    .rdata (head),
    .count (bus.count),
    .full  (full),
    .empty (empty)
  );

  assign bus.memReady = !full;

  // Stage 1: instruction register; reset and flush both clear it.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      ir_p1  <= '0;
      vld_p1 <= 1'b0;
    end else if (bypass) begin
      ir_p1  <= bus.memData;
      vld_p1 <= 1'b1;
    end else if (pop) begin
      ir_p1  <= head;
      vld_p1 <= 1'b1;
    end
  end

  for (genvar k = 0; k < NFIELD; k++) begin : g_field
    assign bus.irFields[k*FIELD_W +: FIELD_W] = ir_p1[k*FIELD_W +: FIELD_W];
  end
  assign bus.irValid = vld_p1;
endmodule
